// File: rtl/mem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_pkg : shared RAM command codes and arbiter types.   Rev 1.0
// ----------------------------------------------------------------------------
package mem_pkg;

  localparam logic [1:0] MREAD  = 2'd1;
  localparam logic [1:0] MNONE  = 2'd2;
  localparam logic [1:0] MWRITE = 2'd3;

  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arb_pick : winner select, D priority with an F starvation guard. Rev 1.0
// ----------------------------------------------------------------------------
module mem_arb_pick
  import mem_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic                f_req,
  input  logic                d_req,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_valid,
  output logic                owner
);

  logic   starve;
  owner_t win;

  always_comb begin
    // F takes the slot once D has won MAX_STREAK times in a row over it
    starve = f_req && (streak == STREAK_W'(MAX_STREAK));
    win    = (d_req && !starve) ? OWN_D : OWN_F;
  end

  assign grant_valid = f_req | d_req;
  assign owner       = win;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter : shares the single-port RAM between fetch (F) and data (D).
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int AW         = 9,
  parameter int DW         = 16,
  parameter int READ_LAT   = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] write_data,
  input  logic [DW-1:0] read_data,
  output logic          busy
);

  arb_state_t          state, state_n;
  owner_t              own;
  logic                own_we;
  logic [2:0]          cnt;
  logic [STREAK_W-1:0] streak;

  logic                grant_valid;
  logic                pick_own;
  logic [1:0]          cmd_n;
  logic                f_ack_n, d_ack_n;
  logic                latch, capture, load_cnt;

  mem_arb_pick #(
    .MAX_STREAK (MAX_STREAK)
  ) u_pick (
    .f_req       (f_req),
    .d_req       (d_req),
    .streak      (streak),
    .grant_valid (grant_valid),
    .owner       (pick_own)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Outputs are registered, so each branch computes the value for the next state
  always_comb begin
    state_n  = state;
    cmd_n    = MNONE;
    f_ack_n  = 1'b0;
    d_ack_n  = 1'b0;
    latch    = 1'b0;
    capture  = 1'b0;
    load_cnt = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_valid) begin
          latch   = 1'b1;
          state_n = ISSUE;
          cmd_n   = (pick_own == OWN_D && d_we) ? MWRITE : MREAD;
        end
      end
      ISSUE: begin
        if (own == OWN_D && own_we) begin
          state_n = ACK;
          d_ack_n = 1'b1;
        end else begin
          state_n  = WAIT;
          cmd_n    = MREAD;
          load_cnt = 1'b1;
        end
      end
      WAIT: begin
        if (cnt == 3'd1) begin
          state_n = ACK;
          capture = 1'b1;
          f_ack_n = (own == OWN_F);
          d_ack_n = (own == OWN_D);
        end else begin
          cmd_n = MREAD;
        end
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_cmd    <= MNONE;
      mem_addr   <= '0;
      write_data <= '0;
      f_ack      <= 1'b0;
      d_ack      <= 1'b0;
      f_rdata    <= '0;
      d_rdata    <= '0;
      busy       <= 1'b0;
      streak     <= '0;
      own        <= OWN_F;
      own_we     <= 1'b0;
      cnt        <= '0;
    end else begin
      mem_cmd <= cmd_n;
      f_ack   <= f_ack_n;
      d_ack   <= d_ack_n;
      busy    <= (state_n != IDLE);

      if (latch) begin
        own    <= owner_t'(pick_own);
        own_we <= (pick_own == OWN_D) && d_we;
        if (pick_own == OWN_D) begin
          mem_addr   <= d_addr;
          write_data <= d_wdata;
          if (!f_req)                                 streak <= '0;
          else if (streak != STREAK_W'(MAX_STREAK))   streak <= streak + 1'b1;
        end else begin
          mem_addr <= f_addr;
          streak   <= '0;
        end
      end

      if (load_cnt)           cnt <= 3'(READ_LAT);
      else if (state == WAIT) cnt <= cnt - 3'd1;

      if (capture) begin
        if (own == OWN_F) f_rdata <= read_data;
        else              d_rdata <= read_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_arbiter : directed bench for mem_arbiter (READ_LAT=1 and READ_LAT=3).
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // instance A: READ_LAT=1
  logic        f_req, d_req, d_we, f_ack, d_ack, busy;
  logic [8:0]  f_addr, d_addr, mem_addr;
  logic [15:0] d_wdata, f_rdata, d_rdata, write_data, read_data;
  logic [1:0]  mem_cmd;

  // instance B: READ_LAT=3
  logic        f_req_b, d_req_b, d_we_b, f_ack_b, d_ack_b, busy_b;
  logic [8:0]  f_addr_b, d_addr_b, mem_addr_b;
  logic [15:0] d_wdata_b, f_rdata_b, d_rdata_b, write_data_b, read_data_b;
  logic [1:0]  mem_cmd_b;

  mem_arbiter #(.AW(9), .DW(16), .READ_LAT(1), .MAX_STREAK(4)) dut_a (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .write_data(write_data),
    .read_data(read_data), .busy(busy)
  );

  mem_arbiter #(.AW(9), .DW(16), .READ_LAT(3), .MAX_STREAK(4)) dut_b (
    .clk(clk), .reset(reset),
    .f_req(f_req_b), .f_addr(f_addr_b), .f_ack(f_ack_b), .f_rdata(f_rdata_b),
    .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
    .d_ack(d_ack_b), .d_rdata(d_rdata_b),
    .mem_cmd(mem_cmd_b), .mem_addr(mem_addr_b), .write_data(write_data_b),
    .read_data(read_data_b), .busy(busy_b)
  );

  function automatic logic [15:0] ram_init(input int a);
    case (a)
      5:       return 16'hA5A5;
      7:       return 16'h7777;
      8:       return 16'h8888;
      32:      return 16'hC001;
      33:      return 16'hC002;
      34:      return 16'hC003;
      35:      return 16'hC004;
      36:      return 16'hC005;
      37:      return 16'hC006;
      48:      return 16'h3030;
      64:      return 16'hF040;
      96:      return 16'hBEEF;
      default: return 16'h0000;
    endcase
  endfunction

  // RAM models: contents preloaded while reset is high, reads pipelined READ_LAT deep
  logic [15:0] ram_a [512];
  logic [15:0] pipe_a;
  logic [15:0] ram_b [512];
  logic [15:0] pipe_b [3];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 512; i++) ram_a[i] <= ram_init(i);
    end else if (mem_cmd == 2'd3) begin
      ram_a[mem_addr] <= write_data;
    end
    pipe_a <= ram_a[mem_addr];
  end
  assign read_data = pipe_a;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 512; i++) ram_b[i] <= ram_init(i);
    end else if (mem_cmd_b == 2'd3) begin
      ram_b[mem_addr_b] <= write_data_b;
    end
    pipe_b[0] <= ram_b[mem_addr_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign read_data_b = pipe_b[2];

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (mem_cmd !== 2'd2) begin errors++; $display("FAIL reset_mem_cmd got=%0h want=2", mem_cmd); end
    checks++; if (mem_addr !== 9'h0) begin errors++; $display("FAIL reset_mem_addr got=%0h want=0", mem_addr); end
    checks++; if (write_data !== 16'h0) begin errors++; $display("FAIL reset_write_data got=%0h want=0", write_data); end
    checks++; if (f_ack !== 1'b0 || d_ack !== 1'b0) begin errors++; $display("FAIL reset_acks got=%b%b want=00", f_ack, d_ack); end
    checks++; if (f_rdata !== 16'h0 || d_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got=%0h/%0h want=0/0", f_rdata, d_rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (dut_a.streak !== 4'd0) begin errors++; $display("FAIL reset_streak got=%0d want=0", dut_a.streak); end
  endtask

  task automatic test_f_read();
    f_addr = 9'h005; f_req = 1'b1;
    @(negedge clk);  // ISSUE
    checks++; if (mem_cmd !== 2'd1 || mem_addr !== 9'h005) begin errors++; $display("FAIL fread_issue got cmd=%0h addr=%0h want cmd=1 addr=5", mem_cmd, mem_addr); end
    checks++; if (busy !== 1'b1 || f_ack !== 1'b0) begin errors++; $display("FAIL fread_issue_busy got busy=%b ack=%b want 1/0", busy, f_ack); end
    @(negedge clk);  // WAIT
    checks++; if (mem_cmd !== 2'd1 || mem_addr !== 9'h005) begin errors++; $display("FAIL fread_wait got cmd=%0h addr=%0h want cmd=1 addr=5", mem_cmd, mem_addr); end
    @(negedge clk);  // ACK
    checks++; if (f_ack !== 1'b1) begin errors++; $display("FAIL fread_ack got=%b want=1", f_ack); end
    checks++; if (f_rdata !== 16'hA5A5) begin errors++; $display("FAIL fread_data got=%0h want=a5a5", f_rdata); end
    checks++; if (mem_cmd !== 2'd2 || d_ack !== 1'b0) begin errors++; $display("FAIL fread_ack_cmd got cmd=%0h d_ack=%b want 2/0", mem_cmd, d_ack); end
    f_req = 1'b0;
    @(negedge clk);  // IDLE
    checks++; if (f_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fread_idle got ack=%b busy=%b want 0/0", f_ack, busy); end
    checks++; if (d_rdata !== 16'h0) begin errors++; $display("FAIL fread_d_rdata_kept got=%0h want=0", d_rdata); end
  endtask

  task automatic test_d_write();
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'h100; d_wdata = 16'h1234;
    @(negedge clk);  // ISSUE
    checks++; if (mem_cmd !== 2'd3 || mem_addr !== 9'h100 || write_data !== 16'h1234) begin errors++; $display("FAIL dwrite_issue got cmd=%0h addr=%0h wd=%0h want 3/100/1234", mem_cmd, mem_addr, write_data); end
    checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL dwrite_early_ack got=%b want=0", d_ack); end
    @(negedge clk);  // ACK
    checks++; if (d_ack !== 1'b1 || mem_cmd !== 2'd2) begin errors++; $display("FAIL dwrite_ack got ack=%b cmd=%0h want 1/2", d_ack, mem_cmd); end
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);  // IDLE
    checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL dwrite_ack_pulse got=%b want=0", d_ack); end
    f_addr = 9'h100; f_req = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (f_ack !== 1'b1 || f_rdata !== 16'h1234) begin errors++; $display("FAIL dwrite_readback got ack=%b data=%0h want 1/1234", f_ack, f_rdata); end
    checks++; if (d_rdata !== 16'h0) begin errors++; $display("FAIL dwrite_d_rdata_kept got=%0h want=0", d_rdata); end
    f_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_collision();
    f_req = 1'b1; f_addr = 9'h007;
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'h008;
    @(negedge clk);  // ISSUE for D
    checks++; if (mem_addr !== 9'h008) begin errors++; $display("FAIL coll_d_first got addr=%0h want=8", mem_addr); end
    repeat (2) @(negedge clk);  // ACK for D
    checks++; if (d_ack !== 1'b1 || f_ack !== 1'b0 || d_rdata !== 16'h8888) begin errors++; $display("FAIL coll_d_ack got d=%b f=%b data=%0h want 1/0/8888", d_ack, f_ack, d_rdata); end
    checks++; if (mem_cmd !== 2'd2) begin errors++; $display("FAIL coll_ack_cmd got=%0h want=2", mem_cmd); end
    d_req = 1'b0;
    @(negedge clk);  // IDLE
    checks++; if (mem_cmd !== 2'd2 || busy !== 1'b0) begin errors++; $display("FAIL coll_idle got cmd=%0h busy=%b want 2/0", mem_cmd, busy); end
    @(negedge clk);  // ISSUE for F
    checks++; if (mem_addr !== 9'h007 || mem_cmd !== 2'd1) begin errors++; $display("FAIL coll_f_issue got addr=%0h cmd=%0h want 7/1", mem_addr, mem_cmd); end
    repeat (2) @(negedge clk);  // ACK for F
    checks++; if (f_ack !== 1'b1 || d_ack !== 1'b0 || f_rdata !== 16'h7777) begin errors++; $display("FAIL coll_f_ack got f=%b d=%b data=%0h want 1/0/7777", f_ack, d_ack, f_rdata); end
    f_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_streak();
    logic [15:0] exp_d [6];
    logic [6:0]  order;
    int nd, nf;
    exp_d = '{16'hC001, 16'hC002, 16'hC003, 16'hC004, 16'hC005, 16'hC006};
    order = '0; nd = 0; nf = 0;
    f_req = 1'b1; f_addr = 9'h040;
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'h020;
    for (int c = 0; c < 100 && (nd + nf) < 7; c++) begin
      @(negedge clk);
      if (d_ack) begin
        checks++; if (d_rdata !== exp_d[nd]) begin errors++; $display("FAIL streak_d_data[%0d] got=%0h want=%0h", nd, d_rdata, exp_d[nd]); end
        nd++;
        order = {order[5:0], 1'b1};
        if (nd == 6) d_req = 1'b0;
        else         d_addr = 9'(32 + nd);
      end
      if (f_ack) begin
        checks++; if (f_rdata !== 16'hF040) begin errors++; $display("FAIL streak_f_data got=%0h want=f040", f_rdata); end
        checks++; if (dut_a.streak !== 4'd0) begin errors++; $display("FAIL streak_clear got=%0d want=0", dut_a.streak); end
        nf++;
        order = {order[5:0], 1'b0};
        f_req = 1'b0;
      end
    end
    checks++; if (order !== 7'b1111011 || (nd + nf) != 7) begin errors++; $display("FAIL streak_order got=%b (%0d acks) want=1111011 (7 acks)", order, nd + nf); end
    @(negedge clk);
    checks++; if (dut_a.streak !== 4'd0) begin errors++; $display("FAIL streak_end got=%0d want=0", dut_a.streak); end
  endtask

  task automatic test_reset_mid();
    logic seen_ack;
    int   lat;
    seen_ack = 1'b0; lat = 0;
    f_addr = 9'h030; f_req = 1'b1;
    repeat (2) @(negedge clk);  // WAIT
    checks++; if (mem_cmd !== 2'd1) begin errors++; $display("FAIL rmid_in_wait got cmd=%0h want=1", mem_cmd); end
    #2 reset = 1'b1;
    #1;
    checks++; if (mem_cmd !== 2'd2 || busy !== 1'b0 || mem_addr !== 9'h0) begin errors++; $display("FAIL rmid_async got cmd=%0h busy=%b addr=%0h want 2/0/0", mem_cmd, busy, mem_addr); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (f_ack) seen_ack = 1'b1;
    end
    checks++; if (seen_ack !== 1'b0) begin errors++; $display("FAIL rmid_no_ack got=%b want=0", seen_ack); end
    reset = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (f_ack) begin lat = c; break; end
    end
    checks++; if (lat != 3) begin errors++; $display("FAIL rmid_reissue_latency got=%0d want=3", lat); end
    checks++; if (f_rdata !== 16'h3030) begin errors++; $display("FAIL rmid_reissue_data got=%0h want=3030", f_rdata); end
    f_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lat3();
    int ncmd, lat;
    ncmd = 0; lat = 0;
    d_req_b = 1'b1; d_we_b = 1'b0; d_addr_b = 9'h060;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_cmd_b == 2'd1) ncmd++;
      if (d_ack_b) begin lat = c; break; end
    end
    checks++; if (ncmd != 4) begin errors++; $display("FAIL lat3_mread_cycles got=%0d want=4", ncmd); end
    checks++; if (lat != 5) begin errors++; $display("FAIL lat3_ack_latency got=%0d want=5", lat); end
    checks++; if (d_rdata_b !== 16'hBEEF || f_ack_b !== 1'b0) begin errors++; $display("FAIL lat3_data got=%0h f_ack=%b want beef/0", d_rdata_b, f_ack_b); end
    d_req_b = 1'b0;
    @(negedge clk);
    checks++; if (d_ack_b !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL lat3_idle got ack=%b busy=%b want 0/0", d_ack_b, busy_b); end
  endtask

  initial begin
    reset = 1'b1;
    f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    f_req_b = 1'b0; f_addr_b = '0; d_req_b = 1'b0; d_we_b = 1'b0; d_addr_b = '0; d_wdata_b = '0;
    test_reset();
    test_f_read();
    test_d_write();
    test_collision();
    test_streak();
    test_reset_mid();
    test_lat3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
